// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM encoding and helpers for alu_seq_hs (divide support under ALU_SEQ_DIV_EN)
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_REMU  = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier / restoring divider (divider under ALU_SEQ_DIV_EN)
module alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hi,
`ifdef ALU_SEQ_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST = (SHW + 1)'(WIDTH - 1);

  logic               busy;
  logic               hi_q;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     add_sum;
`ifdef ALU_SEQ_DIV_EN
  logic               div_q;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
`endif

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    acc_nxt = {add_sum, acc[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opb};
    if (div_q) begin
      acc_nxt = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // the last iteration's result is forwarded so the caller can register it on the same edge
  assign done   = busy && (cnt == LAST);
  assign result = hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      hi_q  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy  <= 1'b1;
      hi_q  <= hi;
      cnt   <= '0;
      acc   <= {{WIDTH{1'b0}}, a};
      opb   <= b;
`ifdef ALU_SEQ_DIV_EN
      div_q <= div;
`endif
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_hs.sv
// rtl/alu_seq_hs.sv - handshaked execute-stage ALU with flags and iterative mul/div (DIVU/REMU under ALU_SEQ_DIV_EN)
module alu_seq_hs
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [4:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rdata,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic             accept, multi, eng_start, eng_done;
  logic [WIDTH-1:0] eng_result;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] diff, res;
  logic [SHW-1:0]   shamt;
  logic             res_c, res_v, res_ill;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign multi     = is_multicycle(aluc);
  assign eng_start = accept && multi;
  assign shamt     = data2[SHW-1:0];

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .hi     ((aluc == OP_MULHU) || (aluc == OP_REMU)),
`ifdef ALU_SEQ_DIV_EN
    .div    ((aluc == OP_DIVU) || (aluc == OP_REMU)),
`endif
    .a      (data1),
    .b      (data2),
    .done   (eng_done),
    .result (eng_result)
  );

  always_comb begin
    sum_ext = {1'b0, data1} + {1'b0, data2};
    diff    = data1 - data2;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
    case (aluc)
      OP_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum_ext[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff;
        res_c = data1 >= data2;
        res_v = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND:  res = data1 & data2;
      OP_OR:   res = data1 | data2;
      OP_XOR:  res = data1 ^ data2;
      OP_NOR:  res = ~(data1 | data2);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, data1 < data2};
      OP_SLL:  res = data1 << shamt;
      OP_SRL:  res = data1 >> shamt;
      OP_SRA:  res = $unsigned($signed(data1) >>> shamt);
      OP_LUI:  res = data2 << (WIDTH / 2);
      default: res_ill = !multi;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (eng_start) state_d = ((aluc == OP_MUL) || (aluc == OP_MULHU)) ? ST_MUL : ST_DIV;
      ST_MUL:  if (eng_done) state_d = ST_IDLE;
`ifdef ALU_SEQ_DIV_EN
      ST_DIV:  if (eng_done) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // a multicycle accept falls through to the transfer branch so a taken old result is retired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rdata     <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !multi) begin
      out_valid <= 1'b1;
      rdata     <= res;
      z         <= (res == '0);
      n         <= res[WIDTH-1];
      c         <= res_c;
      v         <= res_v;
      illegal   <= res_ill;
    end else if (eng_done) begin
      out_valid <= 1'b1;
      rdata     <= eng_result;
      z         <= (eng_result == '0);
      n         <= eng_result[WIDTH-1];
      c         <= 1'b0;
      v         <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_hs.sv
// tb/tb_alu_seq_hs.sv - scoreboard bench for alu_seq_hs (divide cases follow ALU_SEQ_DIV_EN)
module tb_alu_seq_hs;

  localparam int WIDTH = 32;

  typedef struct packed {
    logic [31:0] r;
    logic        z, n, c, v, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic        z, n, c, v, illegal;
  logic [31:0] data1, data2, rdata;
  logic [4:0]  aluc;
  logic        rnd_bp = 1'b0;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_seq_hs #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .aluc      (aluc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rdata     (rdata),
    .z         (z),
    .n         (n),
    .c         (c),
    .v         (v),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic ez, en, ec, ev, eill);
    mk = '{r, ez, en, ec, ev, eill};
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [32:0] w;
    longint      s;
    e = '0;
    case (op)
      5'd0: begin
        w = {1'b0, a} + {1'b0, b};
        e.r = w[31:0];
        e.c = w[32];
        s = longint'($signed(a)) + longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd1: begin
        e.r = a - b;
        e.c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2:  e.r = a & b;
      5'd3:  e.r = a | b;
      5'd4:  e.r = a ^ b;
      5'd5:  e.r = ~(a | b);
      5'd6:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:  e.r = (a < b) ? 32'd1 : 32'd0;
      5'd8:  e.r = a << b[4:0];
      5'd9:  e.r = a >> b[4:0];
      5'd10: e.r = $signed(a) >>> b[4:0];
      5'd11: e.r = {b[15:0], 16'h0000};
      5'd16: begin p = 64'(a) * 64'(b); e.r = p[31:0]; end
      5'd17: begin p = 64'(a) * 64'(b); e.r = p[63:32]; end
`ifdef ALU_SEQ_DIV_EN
      5'd18: e.r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd19: e.r = (b == 0) ? a : a % b;
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.r == 32'd0);
    e.n = e.r[31];
    return e;
  endfunction

  // called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int t = 0;
    aluc = op; data1 = a; data2 = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    chk("accept", 32'(in_ready), 32'd1);
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'(sbq.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rdata", rdata, e.r);
        chk("z", 32'(z), 32'(e.z));
        chk("n", 32'(n), 32'(e.n));
        chk("c", 32'(c), 32'(e.c));
        chk("v", 32'(v), 32'(e.v));
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d errors before abort", errors);
    $fatal(1, "watchdog");
  end

  logic [4:0] ops [18] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                           5'd9, 5'd10, 5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd13, 5'd31};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    data1 = '0; data2 = '0; aluc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {27'd0, z, n, c, v, illegal}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    send(5'd1, 32'd32, 32'd15, mk(32'd17, 0, 0, 1, 0, 0));
    @(negedge clk);
    chk("sub_latency", 32'(out_valid), 32'd1);
    chk("sub_rdata", rdata, 32'd17);
    @(posedge clk); #1;
    send(5'd1, 32'd12, 32'd12, mk(32'd0, 1, 0, 1, 0, 0));
    send(5'd6, 32'd12, 32'd15, mk(32'd1, 0, 0, 0, 0, 0));

    send(5'd16, 32'hFFFF_FFFF, 32'd2, mk(32'hFFFF_FFFE, 0, 1, 0, 0, 0));
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("mul_in_ready", 32'(in_ready), 32'd0);
      chk("mul_out_valid_early", 32'(out_valid), 32'd0);
      data1 = $urandom; data2 = $urandom;
    end
    @(negedge clk);
    chk("mul_out_valid", 32'(out_valid), 32'd1);
    chk("mul_rdata", rdata, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    send(5'd17, 32'hFFFF_FFFF, 32'd2, mk(32'd1, 0, 0, 0, 0, 0));
    drain();

    out_ready = 1'b0;
    send(5'd0, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 0, 1, 0, 1, 0));
    in_valid = 1'b1; aluc = 5'd0; data1 = 32'd5; data2 = 32'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_rdata", rdata, 32'h8000_0000);
      chk("bp_vn", {30'd0, v, n}, 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(5'd0, 32'd5, 32'd6, mk(32'd11, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("same_edge_out_valid", 32'(out_valid), 32'd1);
    chk("same_edge_rdata", rdata, 32'd11);
    @(posedge clk); #1;
    drain();

    send(5'd16, 32'd3, 32'd5, mk(32'd15, 0, 0, 0, 0, 0));
    repeat (10) @(negedge clk);
    chk("mid_mul_in_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_rdata", rdata, 32'd0);
    chk("async_rst_flags", {27'd0, z, n, c, v, illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(5'd0, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid), 32'd1);
    chk("post_rst_rdata", rdata, 32'd7);
    @(posedge clk); #1;
    drain();

`ifdef ALU_SEQ_DIV_EN
    send(5'd18, 32'd100, 32'd7, mk(32'd14, 0, 0, 0, 0, 0));
    send(5'd19, 32'd100, 32'd7, mk(32'd2, 0, 0, 0, 0, 0));
    send(5'd18, 32'd100, 32'd0, mk(32'hFFFF_FFFF, 0, 1, 0, 0, 0));
    send(5'd19, 32'd100, 32'd0, mk(32'd100, 0, 0, 0, 0, 0));
`else
    send(5'd18, 32'd100, 32'd7, mk(32'd0, 1, 0, 0, 0, 1));
    @(negedge clk);
    chk("divu_illegal_latency", 32'(out_valid), 32'd1);
    chk("divu_illegal_flag", 32'(illegal), 32'd1);
    @(posedge clk); #1;
    send(5'd19, 32'd100, 32'd7, mk(32'd0, 1, 0, 0, 0, 1));
`endif
    send(5'd12, 32'd1, 32'd2, mk(32'd0, 1, 0, 0, 0, 1));
    drain();

    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = ops[$urandom_range(0, 17)];
      a = $urandom; b = $urandom;
      if (i % 4 == 0) b = b & 32'h0000_00FF;
      send(op, a, b, model(op, a, b));
    end
    rnd_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
